read_axis_framer: RTL

- Pixel framing stage that feeds the read-path timing generator and AXI-Stream output.
- Accepts raw readout pixels over a valid/ready handshake.
- Maintains the horizontal/vertical position counters (h_count/v_count) that the timing generator consumes.
- Tags each pixel with start-of-frame (tuser) and end-of-line (tlast), buffers it in a small FIFO, and presents it on an AXI-Stream master port with full backpressure.

---
 rtl/read_axis_framer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/read_axis_framer.sv
// read_axis_framer
//   Pixel framing stage between the raw readout and the AXI-Stream output.
//   Counts column/line position of each accepted pixel, tags it with
//   start-of-frame (tuser) and end-of-line (tlast), buffers it in a small
//   FIFO and presents it on an AXI-Stream master port with backpressure.
//
// Ports
//   eim_clk, rst_n_eim          clock, async active-low reset
//   max_h_count, max_v_count    frame size, latched on an accepted frame_start
//   frame_start, frame_reset    arm a new frame / synchronous abort + flush
//   in_valid, in_data, in_ready pixel input handshake
//   m_axis_*                    AXI-Stream master (tdata/tvalid/tready/tlast/tuser)
//   h_count, v_count            write-side position of the next pixel
//   frame_active                frame accepting or draining
//   frame_done                  one-cycle pulse when the last pixel has left
//   fifo_level                  exact number of buffered entries
//   cfg_err, abort_err          sticky: bad frame size / abort during a frame
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no frame armed; input blocked; waits for frame_start
// ACTIVE | accepting pixels, counting h/v position
// DRAIN  | all pixels of the frame accepted; waiting for FIFO to empty

module read_axis_framer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          eim_clk,
    input  logic                          rst_n_eim,
    input  logic [CNT_W-1:0]              max_h_count,
    input  logic [CNT_W-1:0]              max_v_count,
    input  logic                          frame_start,
    input  logic                          frame_reset,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [CNT_W-1:0]              h_count,
    output logic [CNT_W-1:0]              v_count,
    output logic                          frame_active,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          cfg_err,
    output logic                          abort_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t           state;
    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [CNT_W-1:0] h_max_lat;
    logic [CNT_W-1:0] v_max_lat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             h_last;
    logic             v_last;
    logic             sof;
    logic [EW-1:0]    head;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_level = wr_ptr - rd_ptr;

    assign in_ready      = (state == S_ACTIVE) && !fifo_full;
    assign push          = in_valid && in_ready;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign frame_active  = (state != S_IDLE);

    assign h_last = (h_count == h_max_lat - CNT_W'(1));
    assign v_last = (v_count == v_max_lat - CNT_W'(1));
    assign sof    = (h_count == '0) && (v_count == '0);

    // Output side depends only on pointers and storage. Fields are forced to
    // zero while empty so the port is clean out of reset without resetting
    // the storage array.
    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_empty ? '0 : head[DATA_W-1:0];
    assign m_axis_tlast  = !fifo_empty && head[DATA_W];
    assign m_axis_tuser  = !fifo_empty && head[DATA_W+1];

    always_ff @(posedge eim_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {sof, h_last, in_data};
        end
    end

    always_ff @(posedge eim_clk or negedge rst_n_eim) begin
        if (!rst_n_eim) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            h_count    <= '0;
            v_count    <= '0;
            h_max_lat  <= '0;
            v_max_lat  <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            abort_err  <= 1'b0;
        end else if (frame_reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            h_count    <= '0;
            v_count    <= '0;
            frame_done <= 1'b0;
            if (state != S_IDLE) begin
                abort_err <= 1'b1;
            end
        end else begin
            frame_done <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        if ((max_h_count >= CNT_W'(2)) && (max_v_count != '0)) begin
                            h_max_lat <= max_h_count;
                            v_max_lat <= max_v_count;
                            h_count   <= '0;
                            v_count   <= '0;
                            cfg_err   <= 1'b0;
                            abort_err <= 1'b0;
                            state     <= S_ACTIVE;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (push) begin
                        if (h_last) begin
                            h_count <= '0;
                            if (v_last) begin
                                v_count <= '0;
                                state   <= S_DRAIN;
                            end else begin
                                v_count <= v_count + CNT_W'(1);
                            end
                        end else begin
                            h_count <= h_count + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Done once the final buffered entry has been accepted.
                    if (fifo_empty || (pop && (fifo_level == (AW+1)'(1)))) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
